// File: rtl/action_scheduler.sv
// rtl/action_scheduler.sv - arbitrates queued player actions against gravity ticks toward the game engine
//
// action_scheduler_pkg : control_type action encoding shared by queue, scheduler and engine.
// action_scheduler     : one-at-a-time action issue over a valid/done handshake.
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   game running; low freezes the gravity timer and blocks new grants
//   level         in   game level 0..15, shortens the gravity period
//   user_ctrl     in   head of the player-input queue, NOEVENT when empty
//   user_ready    out  one-cycle pop pulse to the input queue, only in a user grant cycle
//   act           out  action presented to the engine, NOEVENT when idle
//   act_valid     out  act is valid, held until act_done
//   act_done      in   engine finished act, ignored while act_valid is low
//   dropped_ticks out  saturating count of gravity ticks lost while one was already pending

package action_scheduler_pkg;
    typedef enum logic [2:0] {
        NOEVENT = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        DOWN    = 3'd3,
        ROTATE  = 3'd4,
        DROP    = 3'd5,
        HOLD    = 3'd6
    } control_type;
endpackage

module action_scheduler
    import action_scheduler_pkg::*;
#(
    parameter int unsigned GRAVITY_TICKS = 100_000_000,
    parameter int unsigned SPEEDUP_TICKS = 5_000_000,
    parameter int unsigned MIN_TICKS     = 10_000_000,
    parameter int          TIMER_W       = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [3:0]  level,
    input  control_type user_ctrl,
    output logic        user_ready,
    output control_type act,
    output logic        act_valid,
    input  logic        act_done,
    output logic [7:0]  dropped_ticks
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [TIMER_W-1:0] GRAV_T  = TIMER_W'(GRAVITY_TICKS);
    localparam logic [TIMER_W-1:0] SPEED_T = TIMER_W'(SPEEDUP_TICKS);
    localparam logic [TIMER_W-1:0] MIN_T   = TIMER_W'(MIN_TICKS);
    // Any speedup product at or beyond this would push the period below the floor.
    localparam logic [TIMER_W-1:0] FLOOR_PRODUCT = GRAV_T - MIN_T;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               grav_pend_q, grav_pend_d;
    logic               last_grav_q, last_grav_d;
    control_type        act_q, act_d;
    logic               act_valid_q, act_valid_d;
    logic [7:0]         dropped_q, dropped_d;

    logic [TIMER_W-1:0] level_w;
    logic [TIMER_W-1:0] speedup;
    logic [TIMER_W-1:0] period;
    logic [TIMER_W-1:0] period_m1;
    logic               tick;
    logic               user_req;
    logic               grant_grav;
    logic               grant_user;
    logic               new_piece;
    logic               pend_kept;

    assign level_w   = TIMER_W'(level);
    assign speedup   = level_w * SPEED_T;
    // Compare before subtracting so the period can never wrap.
    assign period    = (speedup >= FLOOR_PRODUCT) ? MIN_T : (GRAV_T - speedup);
    assign period_m1 = period - TIMER_W'(1);

    // >= rather than == so a level-up that shrinks the period below the
    // running count still fires on the next cycle instead of wrapping.
    assign tick      = enable && (timer_q >= period_m1);
    assign user_req  = (user_ctrl != NOEVENT);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        grav_pend_d = grav_pend_q;
        last_grav_d = last_grav_q;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        dropped_d   = dropped_q;
        grant_grav  = 1'b0;
        grant_user  = 1'b0;
        new_piece   = 1'b0;
        pend_kept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    // Alternate on contention: the side that did not win last time goes first.
                    if (grav_pend_q && (!user_req || !last_grav_q)) begin
                        grant_grav = 1'b1;
                    end else if (user_req) begin
                        grant_user = 1'b1;
                    end
                end
                if (grant_grav) begin
                    act_d       = DOWN;
                    last_grav_d = 1'b1;
                    act_valid_d = 1'b1;
                    state_d     = ISSUE;
                end else if (grant_user) begin
                    act_d       = user_ctrl;
                    last_grav_d = 1'b0;
                    act_valid_d = 1'b1;
                    state_d     = ISSUE;
                    new_piece   = (user_ctrl == DROP) || (user_ctrl == HOLD);
                end else begin
                    act_d = NOEVENT;
                end
            end
            ISSUE: begin
                if (act_done) begin
                    act_d       = NOEVENT;
                    act_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enable) begin
            timer_d = tick ? '0 : (timer_q + TIMER_W'(1));
        end

        // A pending tick consumed by this cycle's grant leaves room for a new
        // tick arriving in the same cycle; only an unconsumed one counts as lost.
        pend_kept   = grav_pend_q && !grant_grav;
        grav_pend_d = pend_kept;
        if (new_piece) begin
            // A new piece restarts the gravity period and discards any tick.
            timer_d     = '0;
            grav_pend_d = 1'b0;
        end else if (tick) begin
            grav_pend_d = 1'b1;
            if (pend_kept && (dropped_q != 8'hFF)) begin
                dropped_d = dropped_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            grav_pend_q <= 1'b0;
            last_grav_q <= 1'b0;
            act_q       <= NOEVENT;
            act_valid_q <= 1'b0;
            dropped_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            grav_pend_q <= grav_pend_d;
            last_grav_q <= last_grav_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            dropped_q   <= dropped_d;
        end
    end

    // Gated by reset_n so the pop pulse drops immediately on an asynchronous reset.
    assign user_ready    = grant_user && reset_n;
    assign act           = act_q;
    assign act_valid     = act_valid_q;
    assign dropped_ticks = dropped_q;

endmodule

// File: tb/tb_action_scheduler.sv
// tb/tb_action_scheduler.sv - scoreboard bench for action_scheduler with a behavioural reference model
module tb_action_scheduler;
    import action_scheduler_pkg::*;

    localparam int GT = 100;
    localparam int ST = 10;
    localparam int MT = 30;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  level = 4'd0;
    control_type user_ctrl = NOEVENT;
    logic        user_ready;
    control_type act;
    logic        act_valid;
    logic        act_done = 1'b0;
    logic [7:0]  dropped_ticks;

    action_scheduler #(
        .GRAVITY_TICKS(GT), .SPEEDUP_TICKS(ST), .MIN_TICKS(MT), .TIMER_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .level(level),
        .user_ctrl(user_ctrl), .user_ready(user_ready), .act(act),
        .act_valid(act_valid), .act_done(act_done), .dropped_ticks(dropped_ticks)
    );

    always #5 clk = ~clk;

    typedef struct {
        control_type a;
        int          c;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        exp_q[$];
    control_type uq[$];
    int          rise_cnt = 0;
    int          rise_cyc[$];
    control_type rise_act[$];
    bit          eng_hold = 0;
    bit          lat_rand = 0;
    int          fixed_lat = 1;
    bit          spur_en = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rc(input int i);
        return (i < rise_cyc.size()) ? rise_cyc[i] : -1;
    endfunction

    function automatic int ra(input int i);
        return (i < rise_act.size()) ? int'(rise_act[i]) : -1;
    endfunction

    // Gravity period straight from the level rule, in plain integers.
    function automatic int period_of(input int lv);
        if (lv * ST >= GT - MT) return MT;
        return GT - lv * ST;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Input queue: pops the head after the DUT pulses user_ready.
    initial begin : user_queue
        bit pop_now;
        pop_now = 0;
        forever begin
            @(negedge clk);
            pop_now = user_ready && reset_n;
            @(posedge clk);
            #2;
            if (pop_now && uq.size() > 0) void'(uq.pop_front());
            user_ctrl = (uq.size() > 0) ? uq[0] : NOEVENT;
        end
    end

    // Engine: answers act_valid with a one-cycle act_done after some latency.
    initial begin : engine
        int wt;
        wt = -1;
        forever begin
            @(posedge clk);
            #3;
            if (!reset_n) begin
                act_done = 1'b0;
                wt = -1;
            end else if (act_done) begin
                act_done = 1'b0;
                wt = -1;
            end else if (act_valid) begin
                if (!eng_hold) begin
                    if (wt < 0) wt = lat_rand ? int'($urandom_range(0, 4)) : fixed_lat;
                    if (wt == 0) act_done = 1'b1;
                    else wt--;
                end
            end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
                act_done = 1'b1;
            end
        end
    end

    // Reference model: decides grants, pending gravity and losses from the rules.
    initial begin : model
        int m_cnt, m_drop, per;
        bit m_pend, m_last, m_busy, en, usr, gg, gu, tk, newp, p;
        m_cnt = 0; m_drop = 0; m_pend = 0; m_last = 0; m_busy = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_cnt = 0; m_drop = 0; m_pend = 0; m_last = 0; m_busy = 0;
                exp_q.delete();
            end else begin
                per = period_of(int'(level));
                en  = enable;
                usr = (user_ctrl != NOEVENT);
                gg  = 0;
                gu  = 0;
                if (en && !m_busy) begin
                    if (m_pend && (!usr || !m_last)) gg = 1;
                    else if (usr) gu = 1;
                end
                chk("user_ready", int'(user_ready), int'(gu));
                chk("dropped_ticks", int'(dropped_ticks), m_drop);
                tk   = en && (m_cnt >= per - 1);
                newp = gu && (user_ctrl == DROP || user_ctrl == HOLD);
                if (m_busy && act_done) m_busy = 0;
                if (en) m_cnt = tk ? 0 : m_cnt + 1;
                p = m_pend && !gg;
                if (newp) begin
                    m_cnt = 0;
                    p = 0;
                end else if (tk) begin
                    if (p && m_drop < 255) m_drop++;
                    p = 1;
                end
                m_pend = p;
                if (gg) begin
                    exp_q.push_back('{a: DOWN, c: cyc + 1});
                    m_last = 1;
                    m_busy = 1;
                end else if (gu) begin
                    exp_q.push_back('{a: user_ctrl, c: cyc + 1});
                    m_last = 0;
                    m_busy = 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every act_valid rise and checks the held action.
    initial begin : monitor
        bit prev_v;
        control_type cur;
        exp_t e;
        prev_v = 0;
        cur = NOEVENT;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_v = 0;
                rise_cnt = 0;
                rise_cyc.delete();
                rise_act.delete();
            end else begin
                if (act_valid && !prev_v) begin
                    rise_cnt++;
                    rise_cyc.push_back(cyc);
                    rise_act.push_back(act);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_grant", int'(act), int'(NOEVENT));
                        cur = act;
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_act", int'(act), int'(e.a));
                        chk("grant_cycle", cyc, e.c);
                        cur = e.a;
                    end
                end else if (act_valid) begin
                    chk("held_act", int'(act), int'(cur));
                end else begin
                    chk("idle_act", int'(act), int'(NOEVENT));
                end
                prev_v = act_valid;
            end
        end
    end

    task automatic wait_rises(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (rise_cnt < n && k < budget) begin
            step();
            k++;
        end
        if (rise_cnt < n) begin
            total++;
            bad++;
            $display("FAIL %s: timeout, rises got %0d want %0d", nm, rise_cnt, n);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0;
        eng_hold = 0;
        lat_rand = 0;
        fixed_lat = 1;
        spur_en = 0;
        uq.delete();
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin : main
        int c0, lows;
        // Reset state
        reset_n = 1'b0;
        step();
        step();
        chk("rst_act_valid", int'(act_valid), 0);
        chk("rst_act", int'(act), int'(NOEVENT));
        chk("rst_user_ready", int'(user_ready), 0);
        chk("rst_dropped", int'(dropped_ticks), 0);
        reset_n = 1'b1;
        step();

        // Gravity timing at level 0
        level = 4'd0;
        enable = 1'b1;
        c0 = cyc;
        wait_rises(3, 400, "grav_wait");
        chk("grav_first_cycle", rc(0), c0 + 101);
        chk("grav_second_cycle", rc(1), c0 + 201);
        chk("grav_third_cycle", rc(2), c0 + 301);
        chk("grav_act", ra(0), int'(DOWN));
        chk("grav_dropped", int'(dropped_ticks), 0);

        // Period floor at level 15
        do_reset();
        level = 4'd15;
        enable = 1'b1;
        c0 = cyc;
        wait_rises(3, 200, "floor_wait");
        chk("floor_first_cycle", rc(0), c0 + 31);
        chk("floor_period", rc(2) - rc(1), 30);

        // DROP granted exactly on the tick cycle restarts the period
        do_reset();
        level = 4'd0;
        enable = 1'b1;
        c0 = cyc;
        wait_cyc(c0 + 99);
        uq.push_back(DROP);
        wait_rises(2, 300, "drop_wait");
        chk("drop_grant_cycle", rc(0), c0 + 100);
        chk("drop_act", ra(0), int'(DROP));
        chk("drop_next_down_cycle", rc(1), c0 + 201);
        chk("drop_next_act", ra(1), int'(DOWN));

        // Arbitration alternation
        do_reset();
        level = 4'd0;
        eng_hold = 1;
        enable = 1'b1;
        uq.push_back(RIGHT);
        wait_rises(1, 10, "arb_first");
        uq.push_back(LEFT);
        repeat (150) step();
        eng_hold = 0;
        wait_rises(3, 50, "arb_second");
        eng_hold = 1;
        uq.push_back(ROTATE);
        repeat (150) step();
        eng_hold = 0;
        wait_rises(5, 50, "arb_third");
        chk("arb_act0", ra(0), int'(RIGHT));
        chk("arb_act1", ra(1), int'(DOWN));
        chk("arb_act2", ra(2), int'(LEFT));
        chk("arb_act3", ra(3), int'(DOWN));
        chk("arb_act4", ra(4), int'(ROTATE));

        // Long stall: two ticks lost, one DOWN after release
        do_reset();
        level = 4'd0;
        enable = 1'b1;
        c0 = cyc;
        wait_rises(1, 200, "stall_first");
        eng_hold = 1;
        lows = 0;
        for (int i = 0; i < 350; i++) begin
            step();
            if (!act_valid) lows++;
        end
        chk("stall_valid_lows", lows, 0);
        chk("stall_dropped", int'(dropped_ticks), 2);
        eng_hold = 0;
        wait_rises(2, 20, "stall_release");
        chk("stall_after_act", ra(1), int'(DOWN));
        wait_cyc(c0 + 495);
        chk("stall_single_down", rise_cnt, 2);

        // Asynchronous reset in the middle of an issue
        do_reset();
        level = 4'd0;
        enable = 1'b1;
        wait_rises(1, 200, "areset_first");
        uq.push_back(LEFT);
        @(posedge clk);
        #4;
        reset_n = 1'b0;
        #1;
        chk("areset_act_valid", int'(act_valid), 0);
        chk("areset_act", int'(act), int'(NOEVENT));
        chk("areset_user_ready", int'(user_ready), 0);
        step();
        step();
        reset_n = 1'b1;
        c0 = cyc;
        wait_rises(2, 200, "areset_restart");
        chk("areset_left_cycle", rc(0), c0 + 1);
        chk("areset_down_cycle", rc(1), c0 + 101);

        // Randomized traffic
        do_reset();
        lat_rand = 1;
        spur_en = 1;
        enable = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 63) == 0) level = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if (uq.size() < 4 && $urandom_range(0, 11) == 0)
                uq.push_back(control_type'($urandom_range(1, 6)));
            if (!eng_hold && $urandom_range(0, 149) == 0) eng_hold = 1;
            else if (eng_hold && $urandom_range(0, 59) == 0) eng_hold = 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/action_scheduler.md
Name: action_scheduler

Overview:
- Sits between the player-input queue and the game engine. Arbitrates queued player actions against periodic gravity DOWN events and issues one action at a time to the engine over a valid/done handshake.
- Owns the level-dependent gravity timer.
- Pops the input queue via a one-cycle ready pulse.

Parameters:
GRAVITY_TICKS, 100_000_000, gravity period in clk cycles at level 0
SPEEDUP_TICKS, 5_000_000, period reduction per level
MIN_TICKS, 10_000_000, floor of the gravity period
TIMER_W, 32, width of gravity counter and period arithmetic

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
enable  input  1  game running; low freezes the timer and blocks new grants
level  input  4  current game level, 0..15
user_ctrl  input  control_type  head of the input queue; NOEVENT = empty
user_ready  output  1  one-cycle pop pulse to the input queue
act  output  control_type  action presented to the engine
act_valid  output  1  act is valid; held until act_done
act_done  input  1  engine finished act; only meaningful while act_valid=1
dropped_ticks  output  8  saturating count of gravity ticks lost while one was already pending

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; act=NOEVENT; act_valid=0; user_ready=0.
  - timer=0; grav_pend=0; last_grav=0; dropped_ticks=0.
- Period:
  - period = GRAVITY_TICKS - level*SPEEDUP_TICKS, computed in TIMER_W bits.
  - If the product is >= GRAVITY_TICKS - MIN_TICKS, period = MIN_TICKS. No underflow allowed.
- Timer:
  - Increments every cycle while enable=1, in any state.
  - When timer >= period-1: timer<=0 and grav_pend<=1. The >= comparison makes a level increase that shrinks the period below the current count fire on the next cycle.
  - If grav_pend is already 1 at a tick, it stays 1 and dropped_ticks increments, saturating at 255.
  - enable=0 holds timer and grav_pend.
- FSM has two states, IDLE and ISSUE.
- IDLE (grant only if enable=1):
  - Requests: G = grav_pend; U = (user_ctrl != NOEVENT).
  - G only: act<=DOWN; grav_pend<=0; last_grav<=1.
  - U only: act<=user_ctrl; user_ready=1 this cycle; last_grav<=0.
  - G and U: user wins if last_grav=1, otherwise gravity wins. This alternation prevents starvation either way.
  - On any grant: act_valid<=1 and state->ISSUE. act_valid rises the cycle after the request is seen.
  - User grant of DROP or HOLD (new piece): timer<=0 and grav_pend<=0 in the same cycle, overriding a simultaneous tick.
  - No request: stay in IDLE; act=NOEVENT.
- ISSUE:
  - act and act_valid are held stable.
  - On act_done=1: act_valid<=0, act<=NOEVENT, state->IDLE.
  - Earliest next grant is the cycle after return to IDLE. act_valid is therefore low for at least one cycle between actions.
- user_ready:
  - Exactly one cycle, only in the grant cycle.
  - Never asserted in ISSUE.
  - user_ctrl is not sampled outside IDLE.
- act_done while act_valid=0 is ignored.
- enable dropping during ISSUE: the current action is not aborted; ISSUE completes on act_done. No new grant is made until enable=1.
- A gravity tick and an act_done in the same cycle are independent. The tick sets grav_pend; the grant happens the following IDLE cycle.

Test Plan:
- Gravity timing: GRAVITY_TICKS=100, level=0, no user input, act_done returned 2 cycles after act_valid. Required: DOWN issued every 100 cycles, first act_valid at cycle 101 after enable, dropped_ticks=0.
- Period floor: SPEEDUP_TICKS=10, MIN_TICKS=30, level=15. Required: period is 30, not underflowed; DOWN every 30 cycles.
- Arbitration: grav_pend=1 and user_ctrl=LEFT pending, last_grav=0. Required: DOWN issued first, then LEFT with a one-cycle user_ready pulse. A second simultaneous request alternates back to gravity.
- DROP reset: user DROP granted in the same cycle the timer hits period-1. Required: timer=0, grav_pend=0, and the next DOWN is a full period later.
- Stall and overflow: GRAVITY_TICKS=100, act_done withheld for 350 cycles. Required: act_valid and act stable throughout, dropped_ticks=2, one DOWN issued after done.
- Async reset mid-ISSUE: assert reset_n=0 off a clock edge. Required: act_valid=0, act=NOEVENT, user_ready=0 immediately; the timer restarts from 0 after release.
